accumulator_alu: RTL and testbench

32-bit accumulator and ALU stage of the DSP datapath. It consumes the sign-extended, pre-shifted 32-bit operand produced by the barrel shifter and performs load, add, subtract, logic and zero-accumulator operations. It also runs a multi-cycle 16-step conditional-subtract division. The accumulator output feeds the parallel shifter for stores to data RAM.

---
 rtl/accumulator_alu.sv | 163 ++++++++++++++++
 tb/tb_accumulator_alu.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_alu.sv
// accumulator_alu: 32-bit accumulator / ALU stage of the DSP datapath.
// Performs LAC, ADD, SUB, AND, OR, XOR and ZAC on the barrel-shifter operand,
// with a sticky signed-overflow flag and optional ADD/SUB saturation.
// Optional feature macro ACC_DIV_EN: when defined, opcode 111 runs a 16-step
// conditional-subtract division (busy/done handshake); when undefined, opcode
// 111 is a NOP and busy/done are tied low with op_ready tied high.
module accumulator_alu #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] operand,
  input  logic         ovm,
  input  logic         ov_clr,
  output logic [W-1:0] acc,
  output logic         ov,
  output logic         busy,
  output logic         done
);

  localparam logic [2:0] OP_LAC = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_ZAC = 3'b110;
  localparam logic [2:0] OP_DIV = 3'b111;

  logic signed [W-1:0] acc_q, acc_d;
  logic                ov_q, ov_d;
  logic                accept;
  logic signed [W-1:0] opnd_s;
  logic signed [W-1:0] add_res, sub_res;
  logic                add_ovf, sub_ovf;

  // Clamp an overflowed ADD/SUB result toward the overflow direction when
  // saturation is enabled; otherwise pass the wrapped result through.
  function automatic logic signed [W-1:0] saturate(
    input logic signed [W-1:0] res,
    input logic                ovf,
    input logic                neg_dir,
    input logic                sat_en
  );
    if (ovf && sat_en) begin
      return neg_dir ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
    return res;
  endfunction

  assign opnd_s  = operand;
  assign add_res = acc_q + opnd_s;
  assign sub_res = acc_q - opnd_s;
  // Signed overflow: the result sign disagrees with the accumulator sign when
  // the effective operand signs agree. The overflow direction is therefore
  // always the accumulator's sign.
  assign add_ovf = (acc_q[W-1] == opnd_s[W-1]) && (add_res[W-1] != acc_q[W-1]);
  assign sub_ovf = (acc_q[W-1] != opnd_s[W-1]) && (sub_res[W-1] != acc_q[W-1]);

`ifdef ACC_DIV_EN
  typedef enum logic {S_IDLE, S_DIV} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic signed [W-1:0] div_q, div_d;
  logic signed [W-1:0] div_diff;
  logic                done_q, done_d;

  assign div_diff = acc_q - div_q;
  assign op_ready = (state_q == S_IDLE);
  assign busy     = (state_q == S_DIV);
  assign done     = done_q;
`else
  assign op_ready = 1'b1;
  assign busy     = 1'b0;
  assign done     = 1'b0;
`endif

  assign accept = op_valid && op_ready;
  assign acc    = acc_q;
  assign ov     = ov_q;

  // Next-state logic: single-cycle ALU ops on acceptance, division steps in DIV.
  always_comb begin
    acc_d = acc_q;
    ov_d  = ov_q & ~ov_clr;
`ifdef ACC_DIV_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    done_d  = 1'b0;
`endif
    if (accept) begin
      case (op)
        OP_LAC: acc_d = opnd_s;
        OP_ADD: begin
          acc_d = saturate(add_res, add_ovf, acc_q[W-1], ovm);
          if (add_ovf) ov_d = 1'b1;
        end
        OP_SUB: begin
          acc_d = saturate(sub_res, sub_ovf, acc_q[W-1], ovm);
          if (sub_ovf) ov_d = 1'b1;
        end
        OP_AND: acc_d = acc_q & opnd_s;
        OP_OR:  acc_d = acc_q | opnd_s;
        OP_XOR: acc_d = acc_q ^ opnd_s;
        OP_ZAC: acc_d = '0;
        OP_DIV: begin
`ifdef ACC_DIV_EN
          state_d = S_DIV;
          cnt_d   = 4'd0;
          div_d   = opnd_s;
`endif
        end
        default: acc_d = acc_q;
      endcase
    end
`ifdef ACC_DIV_EN
    // One conditional-subtract step per cycle; the quotient bit shifts in at
    // the bottom while the partial remainder climbs into the upper half.
    if (state_q == S_DIV) begin
      if (div_diff[W-1]) begin
        acc_d = {acc_q[W-2:0], 1'b0};
      end else begin
        acc_d = {div_diff[W-2:0], 1'b1};
      end
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'd15) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end
`endif
  end

  // State registers; the divisor is pure data and is only loaded on DIV.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      ov_q  <= 1'b0;
`ifdef ACC_DIV_EN
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
`endif
    end else begin
      acc_q <= acc_d;
      ov_q  <= ov_d;
`ifdef ACC_DIV_EN
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`endif
    end
`ifdef ACC_DIV_EN
    div_q <= div_d;
`endif
  end

endmodule

// File: tb/tb_accumulator_alu.sv
// tb_accumulator_alu: scoreboard bench for accumulator_alu. A reference model
// predicts the visible state after every clock edge and queues it; a monitor
// on the falling edge pops and compares. Honours ACC_DIV_EN like the design.
module tb_accumulator_alu;

  localparam logic [2:0] LAC = 3'd0, ADD = 3'd1, SUB = 3'd2, AND_ = 3'd3,
                         OR_ = 3'd4, XOR_ = 3'd5, ZAC = 3'd6, DIV = 3'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op;
  logic [31:0] operand;
  logic        ovm;
  logic        ov_clr;
  logic [31:0] acc;
  logic        ov;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  accumulator_alu #(.W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op       (op),
    .operand  (operand),
    .ovm      (ovm),
    .ov_clr   (ov_clr),
    .acc      (acc),
    .ov       (ov),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    logic [31:0] acc;
    bit          acc_known;
    bit          ov;
    bit          busy;
    bit          done;
    bit          ready;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_acc = '0;
  bit          m_ov = 1'b0;
  int          m_steps = 0;
  logic [31:0] m_res = '0;
  bit          m_done = 1'b0;

  localparam longint MAXP = 64'sd2147483647;
  localparam longint MINN = -64'sd2147483648;

  // Division result from plain integer arithmetic: remainder high, quotient low.
  function automatic logic [31:0] div_model(input logic [31:0] dividend, input logic [31:0] dshift);
    logic [31:0] dv, quo, rem;
    dv  = dshift >> 15;
    quo = dividend / dv;
    rem = dividend % dv;
    return {rem[15:0], quo[15:0]};
  endfunction

  task automatic model_step(input bit v, input logic [2:0] o, input logic [31:0] d,
                            input bit m, input bit c, input bit r);
    bit     set_ov;
    longint s;
    exp_t   e;
    set_ov = 1'b0;
    m_done = 1'b0;
    if (r) begin
      m_acc   = '0;
      m_ov    = 1'b0;
      m_steps = 0;
    end else begin
      if (m_steps > 0) begin
        m_steps--;
        if (m_steps == 0) begin
          m_acc  = m_res;
          m_done = 1'b1;
        end
      end else if (v) begin
        case (o)
          LAC:  m_acc = d;
          AND_: m_acc = m_acc & d;
          OR_:  m_acc = m_acc | d;
          XOR_: m_acc = m_acc ^ d;
          ZAC:  m_acc = '0;
          ADD, SUB: begin
            if (o == ADD) s = longint'($signed(m_acc)) + longint'($signed(d));
            else          s = longint'($signed(m_acc)) - longint'($signed(d));
            if (s > MAXP) begin
              set_ov = 1'b1;
              m_acc  = m ? 32'h7FFF_FFFF : s[31:0];
            end else if (s < MINN) begin
              set_ov = 1'b1;
              m_acc  = m ? 32'h8000_0000 : s[31:0];
            end else begin
              m_acc = s[31:0];
            end
          end
          default: begin
`ifdef ACC_DIV_EN
            m_steps = 16;
            m_res   = div_model(m_acc, d);
`endif
          end
        endcase
      end
      m_ov = (m_ov && !c) || set_ov;
    end
    e.acc       = m_acc;
    e.acc_known = (m_steps == 0);
    e.ov        = m_ov;
    e.busy      = (m_steps > 0);
    e.done      = m_done;
    e.ready     = (m_steps == 0);
    q.push_back(e);
  endtask

  // Drive one cycle of inputs, let the model see the same edge, then settle.
  task automatic cyc(input bit v, input logic [2:0] o, input logic [31:0] d,
                     input bit m, input bit c, input bit r);
    op_valid = v;
    op       = o;
    operand  = d;
    ovm      = m;
    ov_clr   = c;
    reset    = r;
    @(posedge clk);
    model_step(v, o, d, m, c, r);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, LAC, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every predicted post-edge state on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.acc_known) chk("acc", acc, e.acc);
      chk("ov", {31'b0, ov}, {31'b0, e.ov});
      chk("busy", {31'b0, busy}, {31'b0, e.busy});
      chk("done", {31'b0, done}, {31'b0, e.done});
      chk("op_ready", {31'b0, op_ready}, {31'b0, e.ready});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [2:0]  o;
    reset = 1'b1; op_valid = 1'b0; op = LAC; operand = '0; ovm = 1'b0; ov_clr = 1'b0;
    cyc(0, LAC, 0, 0, 0, 1);
    cyc(0, LAC, 0, 0, 0, 1);
    idle(1);

    // Basic arithmetic and logic, back to back
    cyc(1, LAC,  32'h0000_1234, 0, 0, 0);
    cyc(1, ADD,  32'h0000_0010, 0, 0, 0);
    cyc(1, XOR_, 32'h0000_FFFF, 0, 0, 0);
    cyc(1, AND_, 32'h0000_0F0F, 0, 0, 0);
    cyc(1, OR_,  32'hF000_0000, 0, 0, 0);
    cyc(1, ZAC,  32'hDEAD_BEEF, 0, 0, 0);

    // Positive overflow: wrap then saturate
    cyc(1, LAC, 32'h7FFF_FFF0, 0, 0, 0);
    cyc(1, ADD, 32'h0000_0020, 0, 0, 0);
    cyc(1, LAC, 32'h7FFF_FFF0, 0, 0, 0);
    cyc(1, ADD, 32'h0000_0020, 1, 0, 0);
    cyc(0, LAC, 0, 0, 1, 0);

    // Negative saturation, clear, and set-wins-over-clear
    cyc(1, LAC, 32'h8000_0000, 0, 0, 0);
    cyc(1, SUB, 32'h0000_0001, 1, 0, 0);
    cyc(0, LAC, 0, 0, 1, 0);
    cyc(1, SUB, 32'h0000_0001, 1, 1, 0);
    cyc(1, SUB, 32'h7FFF_FFFF, 0, 1, 0);
    cyc(0, LAC, 0, 0, 1, 0);

    // Division 100 / 7 with requests arriving while busy
    cyc(1, LAC, 32'h0000_0064, 0, 0, 0);
    cyc(1, DIV, 32'h0003_8000, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(1, ADD, $urandom, 1, 0, 0);
    idle(2);

    // Reset after eight division steps
    cyc(1, LAC, 32'h0000_0064, 0, 0, 0);
    cyc(1, DIV, 32'h0003_8000, 0, 0, 0);
    idle(8);
    cyc(0, LAC, 0, 0, 0, 1);
    idle(20);

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      if (m_steps == 0 && $urandom_range(0, 9) == 0) begin
        cyc(1, LAC, 32'($urandom_range(0, 32'h7FFF)), 0, 0, 0);
        cyc(1, DIV, 32'($urandom_range(1, 32'h7FFF)) << 15, $urandom_range(0, 1), 0, 0);
      end else begin
        o = 3'($urandom_range(0, 6));
        case ($urandom_range(0, 3))
          0:       d = 32'h7FFF_FFFF - 32'($urandom_range(0, 15));
          1:       d = 32'h8000_0000 + 32'($urandom_range(0, 15));
          default: d = $urandom;
        endcase
        cyc($urandom_range(0, 3) != 0, o, d, $urandom_range(0, 1),
            $urandom_range(0, 7) == 0, 1'b0);
      end
    end
    idle(20);

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
